// File: rtl/wide_add_pkg.sv
// Shared types and sizing helpers for the wide_add_seq multi-precision sequencer.
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LIMB_W = 64;

    // A single-limb build still needs a 1-bit index register.
    function automatic int IDX_W(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/adder_64bit.sv
// Shared 64-bit limb adder with carry-in and carry-out.
module adder_64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        ci,
    output logic        co,
    output logic [63:0] sum
);

    assign {co, sum} = {1'b0, a} + {1'b0, b} + {64'd0, ci};

endmodule

// File: rtl/wide_add_seq.sv
// Multi-precision add/subtract sequencer: one 64-bit limb per cycle through a shared adder.
// Optional zero/ovf flags are enabled by defining WIDE_ADD_SEQ_FLAGS_EN.
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter  int WORDS = 4,
    localparam int OPW   = 64 * WORDS
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic           sub,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic           busy,
    output logic           done,
    output logic [OPW-1:0] result,
`ifdef WIDE_ADD_SEQ_FLAGS_EN
    output logic           zero,
    output logic           ovf,
`endif
    output logic           carry_out
);

    localparam int IW = IDX_W(WORDS);

    state_t              state;
    state_t              next_state;
    logic                accept;
    logic                last;
    logic [IW-1:0]       idx;
    logic                carry;
    logic [OPW-1:0]      a_q;
    logic [OPW-1:0]      b_q;
    logic [LIMB_W-1:0]   limb_a;
    logic [LIMB_W-1:0]   limb_b;
    logic [LIMB_W-1:0]   limb_sum;
    logic                limb_co;

    assign last   = (idx == IW'(WORDS - 1));
    assign limb_a = a_q[idx*LIMB_W +: LIMB_W];
    assign limb_b = b_q[idx*LIMB_W +: LIMB_W];
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    adder_64bit u_adder (
        .a   (limb_a),
        .b   (limb_b),
        .ci  (carry),
        .co  (limb_co),
        .sum (limb_sum)
    );

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last) next_state = DONE;
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: invert b at latch time and seed the carry with sub.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                a_q   <= a;
                b_q   <= sub ? ~b : b;
                carry <= sub;
                idx   <= '0;
            end else if (state == RUN) begin
                result[idx*LIMB_W +: LIMB_W] <= limb_sum;
                carry                        <= limb_co;
                if (last) carry_out <= limb_co;
                else      idx       <= idx + 1'b1;
            end
        end
    end

`ifdef WIDE_ADD_SEQ_FLAGS_EN
    // Signed overflow: carry into the top bit differs from carry out of it.
    logic top_cin;
    assign top_cin = limb_sum[LIMB_W-1] ^ limb_a[LIMB_W-1] ^ limb_b[LIMB_W-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else if (accept) begin
            zero <= 1'b1;
        end else if (state == RUN) begin
            zero <= zero & (limb_sum == '0);
            if (last) ovf <= top_cin ^ limb_co;
        end
    end
`endif

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed self-checking bench for wide_add_seq with WORDS=4 (256-bit operands).
module tb_wide_add_seq;

    localparam int WORDS = 4;
    localparam int OPW   = 64 * WORDS;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           start;
    logic           sub;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic           busy;
    logic           done;
    logic [OPW-1:0] result;
    logic           carry_out;
`ifdef WIDE_ADD_SEQ_FLAGS_EN
    logic           zero;
    logic           ovf;
`endif

    int checks = 0;
    int errors = 0;

    wide_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
`ifdef WIDE_ADD_SEQ_FLAGS_EN
        .zero      (zero),
        .ovf       (ovf),
`endif
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [OPW-1:0] observed,
                               input logic [OPW-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives a one-cycle start pulse; returns at the negedge of the first RUN cycle.
    task automatic applyStimulus(input logic [OPW-1:0] va, input logic [OPW-1:0] vb,
                                 input logic vsub);
        @(negedge clk);
        a     = va;
        b     = vb;
        sub   = vsub;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = '1;
        b     = '1;
        sub   = ~vsub;
    endtask

    // Counts negedges until done, bounded so a stuck DUT cannot hang the run.
    task automatic waitDone(output int cycles);
        cycles = 0;
        while (!done && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    int n;
    int seen;

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        sub     = 1'b0;
        a       = '0;
        b       = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {255'd0, busy}, 256'd0);
        checkOutput("reset_done", {255'd0, done}, 256'd0);
        checkOutput("reset_result", result, 256'd0);
        checkOutput("reset_carry", {255'd0, carry_out}, 256'd0);
        reset_n = 1'b1;

        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checkOutput("idle_no_done", 256'(seen), 256'd0);

        $display("[TB] carry ripple");
        applyStimulus({192'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 256'd1, 1'b0);
        checkOutput("ripple_busy", {255'd0, busy}, 256'd1);
        waitDone(n);
        checkOutput("ripple_latency", 256'(n), 256'd4);
        checkOutput("ripple_result", result, {191'd0, 1'b1, 64'd0});
        checkOutput("ripple_carry", {255'd0, carry_out}, 256'd0);
`ifdef WIDE_ADD_SEQ_FLAGS_EN
        checkOutput("ripple_zero", {255'd0, zero}, 256'd0);
`endif
        @(negedge clk);
        checkOutput("done_pulse_width", {255'd0, done}, 256'd0);
        checkOutput("result_held", result, {191'd0, 1'b1, 64'd0});

        $display("[TB] full wrap");
        applyStimulus({OPW{1'b1}}, 256'd1, 1'b0);
        waitDone(n);
        checkOutput("wrap_latency", 256'(n), 256'd4);
        checkOutput("wrap_result", result, 256'd0);
        checkOutput("wrap_carry", {255'd0, carry_out}, 256'd1);
`ifdef WIDE_ADD_SEQ_FLAGS_EN
        checkOutput("wrap_zero", {255'd0, zero}, 256'd1);
`endif

        $display("[TB] subtract with borrow");
        applyStimulus(256'd5, 256'd7, 1'b1);
        waitDone(n);
        checkOutput("borrow_result", result, {{255{1'b1}}, 1'b0});
        checkOutput("borrow_carry", {255'd0, carry_out}, 256'd0);
`ifdef WIDE_ADD_SEQ_FLAGS_EN
        checkOutput("borrow_ovf", {255'd0, ovf}, 256'd0);
        checkOutput("borrow_zero", {255'd0, zero}, 256'd0);
`endif

        // Second start lands in the DONE cycle of this op.
        $display("[TB] back-to-back");
        start = 1'b1;
        a     = 256'd3;
        b     = 256'd4;
        sub   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        a     = '1;
        checkOutput("b2b_no_bubble", {255'd0, busy}, 256'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(n);
        checkOutput("b2b_latency", 256'(n + 1), 256'd4);
        checkOutput("b2b_result", result, 256'd7);
        checkOutput("b2b_carry", {255'd0, carry_out}, 256'd0);
        @(negedge clk);
        checkOutput("midrun_start_ignored", {254'd0, busy, done}, 256'd0);

        $display("[TB] reset mid-op");
        applyStimulus({OPW{1'b1}}, {OPW{1'b1}}, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_busy", {255'd0, busy}, 256'd0);
        checkOutput("abort_result", result, 256'd0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen++;
        end
        reset_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done) seen++;
        end
        checkOutput("abort_no_done", 256'(seen), 256'd0);

        applyStimulus(256'd1000, 256'd1, 1'b1);
        waitDone(n);
        checkOutput("fresh_latency", 256'(n), 256'd4);
        checkOutput("fresh_result", result, 256'd999);
        checkOutput("fresh_carry", {255'd0, carry_out}, 256'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
